// File: rtl/adc_pkg.sv
// Shared definitions for the SAR ADC signal path.
// Holds the controller state encoding, the resolution and default timing constants
// (also used when instantiating the downstream adc_logic decode stage), and a
// helper that sizes the phase timer counter.
package adc_pkg;

    localparam int unsigned AdcWidth        = 5;
    localparam int unsigned AdcSampleCycles = 4;
    localparam int unsigned AdcSettleCycles = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StTrial
    } adc_state_e;

    // Width needed to hold max(a, b); the timer is loaded with (cycles - 1).
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/adc_phase_timer.sv
// Loadable down-counter with a terminal-count flag.
// Times both the sample window and each trial settle window of the SAR controller.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset, clears the count
//   load_i     - load load_val_i into the counter at the next edge
//   load_val_i - value to load (hold length minus one)
//   done_o     - high while the count is zero (final cycle of the hold window)
module adc_phase_timer #(
    parameter int unsigned CntWidth = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [CntWidth-1:0] load_val_i,
    output logic                done_o
);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/adc_sar_ctrl.sv
// Successive-approximation conversion controller.
// Drives the sample/hold switch and the trial-code DAC, samples the comparator once per
// bit (MSB first), and presents the finished code on a valid/ready output. Converts once
// per start, or back-to-back while cont_mode_i is high.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   start_i          - request one conversion (only acted on in idle)
//   cont_mode_i      - free-running conversions
//   abort_i          - cancel the conversion in progress, result untouched
//   cmp_in_i         - registered comparator, 1 means Vin >= DAC(dac_code_o)
//   sample_en_o      - sample/hold switch
//   dac_code_o       - trial code to the DAC
//   busy_o           - conversion in progress
//   result_o         - last completed code
//   result_valid_o   - result_o not yet consumed
//   result_ready_i   - downstream accepts result_o
//   overrun_o        - one-cycle pulse when an unconsumed result is overwritten
module adc_sar_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned Width        = AdcWidth,
    parameter int unsigned SampleCycles = AdcSampleCycles,
    parameter int unsigned SettleCycles = AdcSettleCycles
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             cont_mode_i,
    input  logic             abort_i,
    input  logic             cmp_in_i,
    output logic             sample_en_o,
    output logic [Width-1:0] dac_code_o,
    output logic             busy_o,
    output logic [Width-1:0] result_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             overrun_o
);

    localparam int unsigned TimerW = timer_width(SampleCycles, SettleCycles);
    localparam int unsigned IdxW   = (Width > 1) ? $clog2(Width) : 1;

    localparam logic [TimerW-1:0] SampleLoad = TimerW'(SampleCycles - 1);
    localparam logic [TimerW-1:0] SettleLoad = TimerW'(SettleCycles - 1);
    localparam logic [IdxW-1:0]   MsbIdx     = IdxW'(Width - 1);

    adc_state_e        state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [Width-1:0]  work_q, work_d;
    logic [Width-1:0]  result_q, result_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic              timer_load;
    logic [TimerW-1:0] timer_val;
    logic              timer_done;
    logic              complete;
    logic [Width-1:0]  trial_code;
    logic [Width-1:0]  decided_code;

    adc_phase_timer #(
        .CntWidth(TimerW)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .done_o    (timer_done)
    );

    // Bits below idx_q are always zero in work_q, so the trial code is a single bit-set
    // and a rejected bit is cleared simply by keeping work_q.
    assign trial_code   = work_q | (Width'(1) << idx_q);
    assign decided_code = cmp_in_i ? trial_code : work_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        work_d     = work_q;
        timer_load = 1'b0;
        timer_val  = SettleLoad;
        complete   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!abort_i && (start_i || cont_mode_i)) begin
                    state_d    = StSample;
                    timer_load = 1'b1;
                    timer_val  = SampleLoad;
                end
            end
            StSample: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (timer_done) begin
                    state_d    = StTrial;
                    idx_d      = MsbIdx;
                    work_d     = '0;
                    timer_load = 1'b1;
                    timer_val  = SettleLoad;
                end
            end
            StTrial: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (timer_done) begin
                    work_d = decided_code;
                    if (idx_q == '0) begin
                        complete = 1'b1;
                        if (cont_mode_i) begin
                            state_d    = StSample;
                            timer_load = 1'b1;
                            timer_val  = SampleLoad;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d      = idx_q - 1'b1;
                        timer_load = 1'b1;
                        timer_val  = SettleLoad;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Result register and handshake. A load on the same edge as a consume keeps valid high
    // and is not an overrun, since the previous result was taken.
    always_comb begin
        result_d  = result_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (complete) begin
            result_d  = decided_code;
            valid_d   = 1'b1;
            overrun_d = valid_q && !result_ready_i;
        end else if (valid_q && result_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            work_q    <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            work_q    <= work_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_en_o    = (state_q == StSample);
    assign dac_code_o     = (state_q == StTrial) ? trial_code : '0;
    assign busy_o         = (state_q != StIdle);
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_adc_sar_ctrl.sv
module tb_adc_sar_ctrl;
    import adc_pkg::*;

    localparam int unsigned Lat = AdcSampleCycles + AdcWidth * AdcSettleCycles;  // 14

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cont_mode;
    logic       abort;
    logic       cmp_q;
    logic       sample_en;
    logic [4:0] dac_code;
    logic       busy;
    logic [4:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       overrun;

    int unsigned vin;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct packed {
        logic [4:0] code;
        int         at;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];

    adc_sar_ctrl u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .cont_mode_i   (cont_mode),
        .abort_i       (abort),
        .cmp_in_i      (cmp_q),
        .sample_en_o   (sample_en),
        .dac_code_o    (dac_code),
        .busy_o        (busy),
        .result_o      (result),
        .result_valid_o(result_valid),
        .result_ready_i(result_ready),
        .overrun_o     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator wrapper model: registered (vin >= dac).
    always @(posedge clk) cmp_q <= (vin >= 32'(dac_code));

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: a new result is presented when valid rises, when it is overwritten, or when
    // it stays high across an edge at which the previous one was consumed.
    initial begin
        logic pv, pr;
        exp_t e;
        forever begin
            @(negedge clk);
            pv = result_valid;
            pr = result_ready;
            @(posedge clk);
            #1;
            if (rst_n && result_valid && (!pv || pr || overrun)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0d required=none", result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_code", int'(result), int'(e.code));
                    chk("result_cycle", cyc, e.at);
                    chk("result_overrun", int'(overrun), int'(e.ov));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // One-shot conversion with ready held high; seq[4] is the first (MSB) trial code.
    task automatic run_conv(input int unsigned v, input logic [4:0][4:0] seq,
                            input logic [4:0] res);
        int e0;
        vin = v;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e0 = cyc;
        exp_q.push_back('{code: res, at: e0 + Lat, ov: 1'b0});
        chk("busy_at_e0", int'(busy), 1);
        chk("sample_en_at_e0", int'(sample_en), 1);
        repeat (AdcSampleCycles) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                repeat (AdcSettleCycles) @(posedge clk);
                #1;
            end
            chk("dac_trial", int'(dac_code), int'(seq[4-k]));
        end
        repeat (AdcSettleCycles) @(posedge clk);
        #1;
        chk("busy_after_done", int'(busy), 0);
        @(posedge clk); #1;
    endtask

    // Two continuous conversions, vin 10 then 12, with result_ready low except optionally
    // on the second completion edge.
    task automatic run_cont(input logic ready_on_2nd);
        int e0;
        int drops;
        drops = 0;
        vin = 10;
        result_ready = 1'b0;
        @(posedge clk); #1;
        cont_mode = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        exp_q.push_back('{code: 5'd10, at: e0 + Lat, ov: 1'b0});
        exp_q.push_back('{code: 5'd12, at: e0 + 2 * Lat, ov: !ready_on_2nd});
        for (int k = 1; k <= 2 * Lat; k++) begin
            @(posedge clk); #1;
            if (!busy) drops++;
            if (k == Lat) vin = 12;
            if (k == 2 * Lat - 1 && ready_on_2nd) result_ready = 1'b1;
        end
        chk("cont_busy_drops", drops, 0);
        chk("cont_valid_after_2nd", int'(result_valid), 1);
        @(posedge clk); #1;
        chk("overrun_single_cycle", int'(overrun), 0);
        abort = 1'b1;
        cont_mode = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("cont_abort_idle", int'(busy), 0);
        result_ready = 1'b1;
        @(posedge clk); #1;
        chk("cont_drained", int'(result_valid), 0);
    endtask

    initial begin
        int e0;
        rst_n = 1'b0;
        start = 1'b0;
        cont_mode = 1'b0;
        abort = 1'b0;
        result_ready = 1'b1;
        vin = 0;
        #23;
        chk("rst_sample_en", int'(sample_en), 0);
        chk("rst_dac", int'(dac_code), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        run_conv(19, {5'd16, 5'd24, 5'd20, 5'd18, 5'd19}, 5'd19);
        run_conv(0,  {5'd16, 5'd8,  5'd4,  5'd2,  5'd1},  5'd0);
        run_conv(31, {5'd16, 5'd24, 5'd28, 5'd30, 5'd31}, 5'd31);

        run_cont(1'b0);
        run_cont(1'b1);

        // Abort on the third trial cycle, with start held during the abort.
        vin = 19;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (AdcSampleCycles + 2) @(posedge clk);
        #1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_sample_en", int'(sample_en), 0);
        chk("abort_dac", int'(dac_code), 0);
        chk("abort_result_kept", int'(result), 12);
        chk("abort_valid_kept", int'(result_valid), 0);
        @(posedge clk); #1;
        chk("abort_start_ignored", int'(busy), 0);
        abort = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        chk("abort_stays_idle", int'(busy), 0);

        // Asynchronous reset in the middle of a trial.
        run_conv(3, {5'd16, 5'd8, 5'd4, 5'd2, 5'd3}, 5'd3);
        vin = 19;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (AdcSampleCycles + 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_sample_en", int'(sample_en), 0);
        chk("midrst_dac", int'(dac_code), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_valid", int'(result_valid), 0);
        chk("midrst_overrun", int'(overrun), 0);
        #12;
        rst_n = 1'b1;
        run_conv(21, {5'd16, 5'd24, 5'd20, 5'd22, 5'd21}, 5'd21);

        repeat (4) @(posedge clk);
        #1;
        chk("pending_expected", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_sar_ctrl.md
Name: adc_sar_ctrl

Overview:
- Successive-approximation conversion controller for the LVDT signal path.
- Sequences the sample/hold switch and the trial-code DAC, and samples the analog comparator once per bit.
- Assembles a WIDTH-bit code and presents it on a valid/ready output.
- The result feeds the downstream 5-bit adc_logic decode stage; the block converts one-shot on start or free-runs in continuous mode.

Parameters:
- WIDTH, 5: conversion resolution in bits. Must equal the decode-stage input width.
- SAMPLE_CYCLES, 4: cycles sample_en is held high per conversion. Must be at least 1.
- SETTLE_CYCLES, 2: cycles each trial code is held before the comparator is sampled. Must be at least 1.

Ports:
- clk, input, 1: system clock. All state updates on its rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- start, input, 1: request one conversion. Level-sampled, acted on only in IDLE.
- cont_mode, input, 1: when 1, a new conversion starts automatically after each completion.
- abort, input, 1: cancels the conversion in progress.
- cmp_in, input, 1: comparator output. 1 means Vin >= DAC(dac_code); driven synchronous to clk.
- sample_en, output, 1: sample/hold switch control.
- dac_code, output, WIDTH: trial code to the DAC.
- busy, output, 1: high while not in IDLE.
- result, output, WIDTH: last completed conversion code.
- result_valid, output, 1: result holds an unconsumed conversion.
- result_ready, input, 1: downstream accepts the result.
- overrun, output, 1: one-cycle pulse when an unconsumed result is overwritten.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - sample_en=0, dac_code=0, busy=0, result=0, result_valid=0, overrun=0.
  - Internal bit index and counters are cleared.
- States: IDLE, SAMPLE, TRIAL.
- IDLE:
  - sample_en=0, dac_code=0.
  - start=1 or cont_mode=1 at edge E0 moves the state to SAMPLE. busy=1 from E0.
- SAMPLE:
  - sample_en=1 and dac_code=0 for exactly SAMPLE_CYCLES cycles.
  - On the last of those edges: go to TRIAL, set bit index to WIDTH-1, working register to 0.
- TRIAL, per bit i from MSB to LSB:
  - dac_code = working register with bit i set, held for SETTLE_CYCLES cycles.
  - On the last of those edges, sample cmp_in: if 1, bit i is kept in the working register; if 0, it is cleared.
  - Bits below i stay 0 while bit i is being tried.
- Completion, at the edge that decides bit 0:
  - The final code (working register with bit 0 resolved) loads into result and result_valid becomes 1.
  - If cont_mode=1, go to SAMPLE (busy stays 1). Otherwise go to IDLE (busy=0).
- Latency:
  - result_valid rises at edge E0 + SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES.
  - With defaults this is E0+14.
  - Continuous-mode period is SAMPLE_CYCLES + WIDTH*SETTLE_CYCLES = 14 cycles.
- Output handshake:
  - result_valid && result_ready at an edge clears result_valid, unless a new result loads at that same edge; then result_valid stays 1 with the new value and overrun stays 0.
  - result and result_valid are stable while result_valid=1 and result_ready=0, except on overwrite.
- Overwrite:
  - Completion while result_valid=1 and result_ready=0 replaces result.
  - overrun=1 for exactly that one cycle.
- start:
  - Ignored while busy (no queueing).
  - Accepted in IDLE regardless of result_valid.
- abort:
  - abort=1 in SAMPLE or TRIAL moves to IDLE at the next edge. No result is loaded; result and result_valid are unchanged.
  - abort has priority over start, cont_mode and completion at the same edge.
  - While abort=1, IDLE does not leave.
- Reset mid-conversion: the conversion is discarded and all outputs return to reset values immediately.
- Comparator input:
  - cmp_in is only sampled on decision edges; cmp_in on all other cycles is ignored.
  - No internal synchronizer is included; the comparator wrapper supplies a registered cmp_in.
- Arithmetic: all codes are unsigned WIDTH bits with no carries. Trial codes are formed by bit set/clear only.

Decomposition:
- Shared package adc_pkg holds:
  - the state enum (IDLE, SAMPLE, TRIAL);
  - ADC_WIDTH=5 and the default SAMPLE_CYCLES / SETTLE_CYCLES constants, shared with adc_logic instantiation.
- One sub-module: adc_phase_timer.
  - Loadable down-counter with a terminal-count flag.
  - Counter width is clog2(max(SAMPLE_CYCLES, SETTLE_CYCLES)+1).
  - Used for both the SAMPLE and the TRIAL hold times.
- The bit index and working register stay in adc_sar_ctrl.

Test Plan:
- Bench model cmp_in = (vin >= dac_code), registered. vin=19, start pulse at E0:
  - dac_code steps 16, 24, 20, 18, 19;
  - result=5'b10011 with result_valid=1 at E0+14;
  - busy=0 after E0+14.
- vin=0: result=0. vin=31: result=31. Trial sequence for vin=31 is 16, 24, 28, 30, 31.
- cont_mode=1, result_ready=0, vin=10 then 12:
  - second completion at E0+28 gives result=12 and a single-cycle overrun=1;
  - busy never drops.
- Same setup with result_ready=1 on the completion edge: result_valid stays 1, result=12, overrun=0.
- abort asserted on the third TRIAL cycle: IDLE next edge, sample_en=0, dac_code=0, result unchanged. start held during abort is ignored.
- rst_n pulled low mid-TRIAL (asynchronous, between edges): outputs are 0 immediately. After release, start gives a correct fresh conversion at +14 cycles.
